// File: rtl/shader_dot_unit.sv
// Multicycle lane-masked vector ALU: dot product, lane sum or scalar multiply.
// Fixed modelled latency per op, with valid/ready handshakes on input and output.
module shader_dot_unit #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LANES   = 4,
  parameter int unsigned MUL_LAT = 8,
  parameter int unsigned ACC_LAT = 12
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      iValid,
  output logic                      oInReady,
  input  logic [1:0]                iOp,
  input  logic [LANES-1:0]          iLaneEn,
  input  logic [LANES*DATA_W-1:0]   iA,
  input  logic [LANES*DATA_W-1:0]   iB,
  output logic                      oValid,
  input  logic                      iOutReady,
  output logic [DATA_W-1:0]         oResult,
  output logic                      oZero,
  output logic                      oOverflow,
  output logic                      oOpErr,
  output logic                      oBusy
);

  localparam int unsigned W     = 2 * DATA_W + $clog2(LANES);
  localparam int unsigned CNT_W = 8;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_SUM = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                    state_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [LANES*DATA_W-1:0]   a_q, b_q;
  logic [1:0]                op_q;
  logic [LANES-1:0]          lane_q;
  logic                      in_ready_q, valid_q, zero_q, ovf_q, operr_q, busy_q;
  logic [DATA_W-1:0]         result_q;

  logic [W-1:0]              full_d;
  logic [CNT_W-1:0]          lat_d;

  // Counter preload (latency minus one) for the incoming opcode.
  always_comb begin
    lat_d = CNT_W'(0);
    case (iOp)
      OP_DP:   lat_d = CNT_W'(MUL_LAT + ACC_LAT - 1);
      OP_SUM:  lat_d = CNT_W'(ACC_LAT - 1);
      OP_MUL:  lat_d = CNT_W'(MUL_LAT - 1);
      default: lat_d = CNT_W'(0);
    endcase
  end

  // Full-precision result from the captured operands.
  always_comb begin
    full_d = '0;
    case (op_q)
      OP_DP: begin
        for (int unsigned i = 0; i < LANES; i++) begin
          if (lane_q[i]) begin
            full_d = full_d + W'(a_q[i*DATA_W +: DATA_W]) * W'(b_q[i*DATA_W +: DATA_W]);
          end
        end
      end
      OP_SUM: begin
        for (int unsigned i = 0; i < LANES; i++) begin
          if (lane_q[i]) begin
            full_d = full_d + W'(a_q[i*DATA_W +: DATA_W]);
          end
        end
      end
      OP_MUL:  full_d = W'(a_q[DATA_W-1:0]) * W'(b_q[DATA_W-1:0]);
      default: full_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      lane_q     <= '0;
      in_ready_q <= 1'b1;
      valid_q    <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      ovf_q      <= 1'b0;
      operr_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (iValid) begin
            a_q        <= iA;
            b_q        <= iB;
            op_q       <= iOp;
            lane_q     <= iLaneEn;
            cnt_q      <= lat_d;
            state_q    <= BUSY;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt_q == CNT_W'(0)) begin
            result_q <= full_d[DATA_W-1:0];
            zero_q   <= (full_d[DATA_W-1:0] == '0);
            ovf_q    <= |full_d[W-1:DATA_W];
            operr_q  <= (op_q == 2'b11);
            valid_q  <= 1'b1;
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          // Result and flags stay put until the consumer takes them.
          if (iOutReady) begin
            valid_q    <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign oInReady  = in_ready_q;
  assign oValid    = valid_q;
  assign oResult   = result_q;
  assign oZero     = zero_q;
  assign oOverflow = ovf_q;
  assign oOpErr    = operr_q;
  assign oBusy     = busy_q;

endmodule

// File: tb/tb_shader_dot_unit.sv
// Bench for shader_dot_unit: vector table with a result scoreboard plus
// hand-written backpressure and mid-operation reset sequences.
module tb_shader_dot_unit;

  logic         clk = 1'b0;
  logic         reset;
  logic         iValid;
  logic         oInReady;
  logic [1:0]   iOp;
  logic [3:0]   iLaneEn;
  logic [127:0] iA, iB;
  logic         oValid;
  logic         iOutReady;
  logic [31:0]  oResult;
  logic         oZero, oOverflow, oOpErr, oBusy;

  shader_dot_unit #(.DATA_W(32), .LANES(4), .MUL_LAT(8), .ACC_LAT(12)) dut (
    .clk(clk), .reset(reset), .iValid(iValid), .oInReady(oInReady),
    .iOp(iOp), .iLaneEn(iLaneEn), .iA(iA), .iB(iB), .oValid(oValid),
    .iOutReady(iOutReady), .oResult(oResult), .oZero(oZero),
    .oOverflow(oOverflow), .oOpErr(oOpErr), .oBusy(oBusy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [3:0]   mask;
    logic [127:0] a, b;
    logic [31:0]  res;
    logic         zero, ovf, err;
    int           lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        zero, ovf, err;
    int          lat;
  } exp_t;

  vec_t vecs[10];
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  function automatic logic [127:0] pack4(input logic [31:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one vector; the accept edge is the posedge following this call.
  task automatic issue(input vec_t v);
    exp_t e;
    @(negedge clk);
    chk("in_ready_before_accept", 64'(oInReady), 64'd1);
    iValid  = 1'b1;
    iOp     = v.op;
    iLaneEn = v.mask;
    iA      = v.a;
    iB      = v.b;
    e.res = v.res; e.zero = v.zero; e.ovf = v.ovf; e.err = v.err; e.lat = v.lat;
    sb.push_back(e);
    @(posedge clk);
    #1 iValid = 1'b0;
  endtask

  // Count edges until oValid, then pop the scoreboard and compare.
  task automatic wait_result(input string tag);
    exp_t e;
    int   n;
    bit   early_ready;
    n = 0;
    early_ready = 1'b0;
    while (!oValid && n < 40) begin
      @(posedge clk);
      #1 n++;
      if (oInReady && !oValid) early_ready = 1'b1;
    end
    e = sb.pop_front();
    chk({tag, "_valid"}, 64'(oValid), 64'd1);
    chk({tag, "_latency"}, 64'(n), 64'(e.lat));
    chk({tag, "_in_ready_low_while_busy"}, 64'(early_ready | oInReady), 64'd0);
    chk({tag, "_result"}, 64'(oResult), 64'(e.res));
    chk({tag, "_zero"}, 64'(oZero), 64'(e.zero));
    chk({tag, "_overflow"}, 64'(oOverflow), 64'(e.ovf));
    chk({tag, "_operr"}, 64'(oOpErr), 64'(e.err));
    chk({tag, "_busy"}, 64'(oBusy), 64'd1);
  endtask

  task automatic drain(input string tag);
    @(negedge clk);
    iOutReady = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_drain_valid"}, 64'(oValid), 64'd0);
    chk({tag, "_drain_in_ready"}, 64'(oInReady), 64'd1);
    iOutReady = 1'b0;
  endtask

  initial begin
    vecs[0] = '{2'b00, 4'b1111, pack4(1,2,3,4), pack4(5,6,7,8), 32'd70, 1'b0, 1'b0, 1'b0, 20};
    vecs[1] = '{2'b00, 4'b0111, pack4(1,2,3,4), pack4(5,6,7,8), 32'd38, 1'b0, 1'b0, 1'b0, 20};
    vecs[2] = '{2'b00, 4'b0000, pack4(1,2,3,4), pack4(5,6,7,8), 32'd0,  1'b1, 1'b0, 1'b0, 20};
    vecs[3] = '{2'b10, 4'b0000, pack4(32'h10000,9,9,9), pack4(32'h10000,9,9,9),
                32'd0, 1'b1, 1'b1, 1'b0, 8};
    vecs[4] = '{2'b01, 4'b0011, pack4(32'hFFFFFFFF,2,0,0), pack4(0,0,0,0),
                32'd1, 1'b0, 1'b1, 1'b0, 12};
    vecs[5] = '{2'b11, 4'b1111, pack4(1,2,3,4), pack4(5,6,7,8), 32'd0, 1'b1, 1'b0, 1'b1, 1};
    vecs[6] = '{2'b00, 4'b1010, pack4(1,2,3,4), pack4(5,6,7,8), 32'd44, 1'b0, 1'b0, 1'b0, 20};
    vecs[7] = '{2'b01, 4'b1111, pack4(1,2,3,4), pack4(5,6,7,8), 32'd10, 1'b0, 1'b0, 1'b0, 12};
    // 4*(2^32-1)^2 = 2^66 - 2^35 + 4: low word 4, overflows.
    vecs[8] = '{2'b00, 4'b1111, pack4(32'hFFFFFFFF,32'hFFFFFFFF,32'hFFFFFFFF,32'hFFFFFFFF),
                pack4(32'hFFFFFFFF,32'hFFFFFFFF,32'hFFFFFFFF,32'hFFFFFFFF),
                32'd4, 1'b0, 1'b1, 1'b0, 20};
    vecs[9] = '{2'b10, 4'b1111, pack4(3,100,100,100), pack4(7,100,100,100),
                32'd21, 1'b0, 1'b0, 1'b0, 8};

    reset = 1'b1; iValid = 1'b0; iOp = 2'b00; iLaneEn = '0; iA = '0; iB = '0;
    iOutReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", 64'(oInReady), 64'd1);
    chk("reset_valid", 64'(oValid), 64'd0);
    chk("reset_result", 64'(oResult), 64'd0);
    chk("reset_flags", 64'({oZero, oOverflow, oOpErr, oBusy}), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      issue(vecs[i]);
      wait_result($sformatf("vec%0d", i));
      drain($sformatf("vec%0d", i));
    end

    // Backpressure: result held for 5 cycles while new requests are offered.
    issue(vecs[0]);
    wait_result("bp");
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      iValid = 1'b1; iOp = 2'b01; iLaneEn = 4'b1111;
      iA = pack4(9,9,9,9); iB = pack4(1,1,1,1);
      @(posedge clk);
      #1;
      chk("bp_hold_valid", 64'(oValid), 64'd1);
      chk("bp_hold_result", 64'({oResult, oZero, oOverflow, oOpErr}), 64'({32'd70, 3'b000}));
      chk("bp_hold_in_ready", 64'(oInReady), 64'd0);
    end
    iValid = 1'b0;
    drain("bp");
    // Next op accepted on the very next edge; its latency proves nothing slipped in.
    issue(vecs[1]);
    wait_result("bp_next");
    drain("bp_next");

    // Reset at edge 10 of a DP4 aborts it with no completion.
    @(negedge clk);
    iValid = 1'b1; iOp = vecs[0].op; iLaneEn = vecs[0].mask; iA = vecs[0].a; iB = vecs[0].b;
    @(posedge clk);
    #1 iValid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", 64'(oBusy), 64'd0);
    chk("abort_in_ready", 64'(oInReady), 64'd1);
    chk("abort_outputs", 64'({oValid, oResult, oZero, oOverflow, oOpErr}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    begin
      bit seen = 1'b0;
      for (int c = 0; c < 25; c++) begin
        @(posedge clk);
        #1 if (oValid) seen = 1'b1;
      end
      chk("abort_no_valid", 64'(seen), 64'd0);
    end
    issue(vecs[0]);
    wait_result("post_reset");
    drain("post_reset");

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/shader_dot_unit.md
Name: shader_dot_unit

Overview:
- Parametrised multicycle vector ALU for the vertex shader datapath. Successor to the fixed-width DP4/accumulate units.
- Performs a lane-masked dot product (DP2/DP3/DP4 and wider), a lane-masked sum, or a scalar multiply over LANES lanes of DATA_W-bit unsigned operands.
- Uses a modelled fixed latency per op and a valid/ready handshake on both input and output, so the result can be back-pressured by the register-file writeback.

Parameters:
- DATA_W, 32, width of each lane operand and of the result.
- LANES, 4, number of vector lanes; must be at least 2.
- MUL_LAT, 8, modelled multiply latency in cycles; must be at least 1.
- ACC_LAT, 12, modelled accumulate latency in cycles; must be at least 1. MUL_LAT+ACC_LAT must not exceed 255.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  one clock; reset is synchronous and active-high.
- iValid  in  1  operation request.
- oInReady  out  1  unit can accept an operation.
- iOp  in  2  operation code: 00 DP, 01 SUM, 10 MUL, 11 reserved.
- iLaneEn  in  LANES  lane enable mask; bit i enables lane i.
- iA  in  LANES*DATA_W  operand A; lane i is bits [i*DATA_W +: DATA_W].
- iB  in  LANES*DATA_W  operand B, same packing as iA.
- oValid  out  1  result available.
- iOutReady  in  1  consumer accepts the result.
- oResult  out  DATA_W  low DATA_W bits of the full-precision result.
- oZero  out  1  oResult == 0.
- oOverflow  out  1  full-precision result does not fit in DATA_W bits.
- oOpErr  out  1  completed operation used reserved opcode 11.
- oBusy  out  1  state is not IDLE.

Behaviour:
- State machine states are IDLE, BUSY and DONE.
- Reset, and IDLE after reset: state=IDLE, oInReady=1, oValid=0, oResult=0, oZero=0, oOverflow=0, oOpErr=0, oBusy=0, counter=0.
- Reset asserted in any state, including mid-BUSY or in DONE, aborts the operation. The outputs above hold from the next edge, and no oValid is produced for the aborted op.
- oInReady=1 only in IDLE.
- Accept: iValid and oInReady are both sampled high at edge k. On that edge the unit captures iA, iB, iOp and iLaneEn, enters BUSY, and loads the counter with LAT-1.
- LAT by opcode: DP is MUL_LAT+ACC_LAT; SUM is ACC_LAT; MUL is MUL_LAT; reserved is 1.
- iValid is ignored while not in IDLE. Captured operands do not change until the next accept.
- BUSY, on each edge: if counter==0, register the result and flags, go to DONE and set oValid=1; otherwise decrement the counter. oValid therefore rises after edge k+LAT.
- DONE: oValid, oResult and all flags are held stable until iOutReady=1.
- Drain: on an edge with oValid and iOutReady both high, go to IDLE and clear oValid. The next accept is possible no earlier than the following edge (one bubble cycle).
- Arithmetic is unsigned, computed at full precision W = 2*DATA_W + clog2(LANES) bits:
  - DP = sum over enabled lanes of A[i]*B[i].
  - SUM = sum over enabled lanes of A[i], zero-extended.
  - MUL = A[0]*B[0]; iLaneEn is ignored.
  - Reserved opcode: full result 0 and oOpErr=1.
- Flags:
  - oOverflow = (full result >> DATA_W) != 0.
  - oZero = low DATA_W bits == 0. Overflow and zero can both be 1.
  - oOpErr=0 for the legal opcodes 00, 01 and 10.
- Empty mask on DP or SUM: full latency, result 0, oZero=1, oOverflow=0.
- Flags and result are valid only while oValid=1. They are held until the next completion overwrites them and are not cleared on drain.

Test Plan:
(DATA_W=32, LANES=4, MUL_LAT=8, ACC_LAT=12; accept at edge 0.)
- DP4: A=(1,2,3,4), B=(5,6,7,8), mask 1111 -> oValid after edge 20, oResult=70, oZero=0, oOverflow=0, oOpErr=0; oInReady=0 through edge 20.
- DP3: same operands, mask 0111 -> oResult=38 after edge 20. Repeat with mask 0000 -> oResult=0, oZero=1, oOverflow=0.
- MUL: A0=0x00010000, B0=0x00010000, mask 0000 -> oValid after edge 8, oResult=0, oOverflow=1, oZero=1. Then SUM with A=(0xFFFFFFFF,2,0,0), mask 0011 -> after edge 12, oResult=1, oOverflow=1.
- Backpressure: hold iOutReady=0 for 5 cycles after oValid, pulsing iValid with new operands -> result and flags stable, oInReady=0, no new op accepted. Raise iOutReady -> oValid=0 and oInReady=1 after that edge; accept next op one edge later.
- Reserved opcode 11 -> oValid after edge 1, oResult=0, oOpErr=1, oZero=1. The following legal op completes with oOpErr=0.
- Reset: assert reset at edge 10 of a DP4 -> from edge 10 oBusy=0, oInReady=1, all outputs 0, no oValid for that op. A new DP4 accepted afterwards completes normally 20 edges later.
